// File: rtl/maze_solver_if.sv
// Bus between a maze solver client (master) and maze_solver (slave).
//   start                        request a solve (master -> slave)
//   h_walls, v_walls             wall maps from the maze generator
//   src_x/src_y, dst_x/dst_y     source and destination coordinates
//   busy, done                   solver status; done is a one-cycle result strobe
//   reachable, distance          result, held until the next accepted start
interface maze_solver_if #(
  parameter int unsigned W      = 10,
  parameter int unsigned H      = 15,
  parameter int unsigned DIST_W = 8
);
  logic                   start;
  logic [(H+1)*W-1:0]     h_walls;
  logic [H*(W+1)-1:0]     v_walls;
  logic [3:0]             src_x;
  logic [3:0]             src_y;
  logic [3:0]             dst_x;
  logic [3:0]             dst_y;
  logic                   busy;
  logic                   done;
  logic                   reachable;
  logic [DIST_W-1:0]      distance;

  modport master (
    output start, h_walls, v_walls, src_x, src_y, dst_x, dst_y,
    input  busy, done, reachable, distance
  );

  modport slave (
    input  start, h_walls, v_walls, src_x, src_y, dst_x, dst_y,
    output busy, done, reachable, distance
  );
endinterface

// File: rtl/maze_solver.sv
// Breadth-first wavefront maze solver. On an accepted start it snapshots the
// wall maps and floods from the source cell one BFS ring per clock until the
// destination is reached or the flood stops growing.
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   bus          maze_solver_if.slave: start, walls, coords in; busy, done,
//                reachable, distance out (all outputs registered)
//   reached_map  (only with SOLVER_REACHED_MAP_EN) latched flood region,
//                final with done and held until the next start
// Optional feature macro: SOLVER_REACHED_MAP_EN.
module maze_solver #(
  parameter int unsigned W      = 10,
  parameter int unsigned H      = 15,
  parameter int unsigned DIST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  maze_solver_if.slave      bus
`ifdef SOLVER_REACHED_MAP_EN
  ,
  output logic [W*H-1:0]    reached_map
`endif
);

  localparam int unsigned N    = W * H;
  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StFlood, StDone} state_e;

  state_e               state_q;
  logic [(H+1)*W-1:0]   h_q;
  logic [H*(W+1)-1:0]   v_q;
  logic [N-1:0]         reached_q;
  logic [N-1:0]         reached_nx;
  logic [IdxW-1:0]      dst_idx_q;
  logic [DIST_W-1:0]    iter_q;
  logic                 busy_q, done_q, reachable_q;
  logic [DIST_W-1:0]    distance_q;

  logic                 coord_ok;
  logic [IdxW-1:0]      src_idx, dst_idx;

  always_comb begin
    coord_ok = ({28'd0, bus.src_x} < W) && ({28'd0, bus.src_y} < H) &&
               ({28'd0, bus.dst_x} < W) && ({28'd0, bus.dst_y} < H);
    src_idx  = IdxW'({28'd0, bus.src_y} * W + {28'd0, bus.src_x});
    dst_idx  = IdxW'({28'd0, bus.dst_y} * W + {28'd0, bus.dst_x});
  end

  // One BFS ring: a cell joins if it is already reached or an open neighbour is.
  // Border cells simply have no neighbour on the outside, so there is no wrap.
  for (genvar p = 0; p < N; p++) begin : g_cell
    localparam int unsigned X = p % W;
    localparam int unsigned Y = p / W;
    logic from_up, from_dn, from_lf, from_rt;

    if (Y > 0) begin : g_up
      assign from_up = !h_q[p] && reached_q[p-W];
    end else begin : g_no_up
      assign from_up = 1'b0;
    end
    if (Y < H - 1) begin : g_dn
      assign from_dn = !h_q[p+W] && reached_q[p+W];
    end else begin : g_no_dn
      assign from_dn = 1'b0;
    end
    if (X > 0) begin : g_lf
      assign from_lf = !v_q[p+Y] && reached_q[p-1];
    end else begin : g_no_lf
      assign from_lf = 1'b0;
    end
    if (X < W - 1) begin : g_rt
      assign from_rt = !v_q[p+Y+1] && reached_q[p+1];
    end else begin : g_no_rt
      assign from_rt = 1'b0;
    end

    assign reached_nx[p] = reached_q[p] | from_up | from_dn | from_lf | from_rt;
  end

  // Outer border wall bits never gate a move; they are latched but unused.
  logic unused_walls;
  assign unused_walls = ^{h_q, v_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      reached_q   <= '0;
      dst_idx_q   <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reachable_q <= 1'b0;
      distance_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            h_q       <= bus.h_walls;
            v_q       <= bus.v_walls;
            dst_idx_q <= dst_idx;
            iter_q    <= '0;
            busy_q    <= 1'b1;
            if (coord_ok) begin
              reached_q <= {{(N-1){1'b0}}, 1'b1} << src_idx;
              state_q   <= StFlood;
            end else begin
              reached_q   <= '0;
              reachable_q <= 1'b0;
              distance_q  <= '0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StFlood: begin
          if (reached_q[dst_idx_q]) begin
            reachable_q <= 1'b1;
            distance_q  <= iter_q;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else if (reached_nx == reached_q) begin
            // Flood stalled: iter is the number of rings expanded.
            reachable_q <= 1'b0;
            distance_q  <= iter_q;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            reached_q <= reached_nx;
            if (iter_q != {DIST_W{1'b1}}) iter_q <= iter_q + 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reachable = reachable_q;
  assign bus.distance  = distance_q;

`ifdef SOLVER_REACHED_MAP_EN
  assign reached_map = reached_q;
`endif

endmodule

// File: tb/tb_maze_solver.sv
module tb_maze_solver;
  localparam int unsigned W  = 10;
  localparam int unsigned H  = 15;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_solver_if #(.W(W), .H(H), .DIST_W(DW)) bus ();

`ifdef SOLVER_REACHED_MAP_EN
  logic [W*H-1:0] reached_map;
`endif

  maze_solver #(.W(W), .H(H), .DIST_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SOLVER_REACHED_MAP_EN
    ,
    .reached_map (reached_map)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Drives one request and watches done; cyc counts edges from the start edge
  // (start edge = 1), so a result at distance d is expected at cyc d+2.
  task automatic run_solve(input logic [3:0] sx, input logic [3:0] sy,
                           input logic [3:0] dx, input logic [3:0] dy,
                           output int cyc, output int pulses);
    cyc = -1;
    pulses = 0;
    bus.src_x = sx; bus.src_y = sy; bus.dst_x = dx; bus.dst_y = dy;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (bus.done) begin
        pulses++;
        if (cyc < 0) cyc = n;
      end
      if (cyc >= 0 && n > cyc + 2) break;
      @(posedge clk); #1;
    end
  endtask

  // Row-by-row snake: rows open horizontally, one gap per row boundary,
  // alternating right end (even row above) and left end (odd row above).
  task automatic set_snake(input logic close_gap_2_3);
    bus.h_walls = '1;
    bus.v_walls = '0;
    for (int y = 0; y < int'(H); y++) begin
      bus.v_walls[y*(W+1)]     = 1'b1;
      bus.v_walls[y*(W+1) + W] = 1'b1;
    end
    for (int y = 0; y < int'(H) - 1; y++) begin
      bus.h_walls[(y+1)*W + ((y % 2 == 0) ? W-1 : 0)] = 1'b0;
    end
    if (close_gap_2_3) bus.h_walls[3*W + 9] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.h_walls = '0; bus.v_walls = '0;
    bus.src_x = '0; bus.src_y = '0; bus.dst_x = '0; bus.dst_y = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.reachable !== 1'b0) begin errors++; $display("FAIL reset_reach got %b want 0", bus.reachable); end
    checks++; if (bus.distance !== 8'd0) begin errors++; $display("FAIL reset_dist got %0d want 0", bus.distance); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_open_field();
    int cyc, pulses;
    bus.h_walls = '0; bus.v_walls = '0;
    run_solve(4'd0, 4'd0, 4'd9, 4'd14, cyc, pulses);
    checks++; if (cyc !== 25) begin errors++; $display("FAIL open_cycle got %0d want 25", cyc); end
    checks++; if (bus.reachable !== 1'b1) begin errors++; $display("FAIL open_reach got %b want 1", bus.reachable); end
    checks++; if (bus.distance !== 8'd23) begin errors++; $display("FAIL open_dist got %0d want 23", bus.distance); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL open_pulses got %0d want 1", pulses); end
`ifdef SOLVER_REACHED_MAP_EN
    checks++; if (reached_map !== {(W*H){1'b1}}) begin errors++; $display("FAIL open_map got %h want all ones", reached_map); end
`endif
  endtask

  task automatic test_same_cell();
    int cyc, pulses;
    bus.h_walls = '1;
    for (int i = 0; i < int'(H*(W+1)); i++) bus.v_walls[i] = i[0];
    run_solve(4'd4, 4'd7, 4'd4, 4'd7, cyc, pulses);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL same_cycle got %0d want 2", cyc); end
    checks++; if (bus.reachable !== 1'b1) begin errors++; $display("FAIL same_reach got %b want 1", bus.reachable); end
    checks++; if (bus.distance !== 8'd0) begin errors++; $display("FAIL same_dist got %0d want 0", bus.distance); end
  endtask

  task automatic test_all_walls();
    int cyc, pulses;
    bus.h_walls = '1; bus.v_walls = '1;
    run_solve(4'd0, 4'd0, 4'd1, 4'd0, cyc, pulses);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL walled_cycle got %0d want 2", cyc); end
    checks++; if (bus.reachable !== 1'b0) begin errors++; $display("FAIL walled_reach got %b want 0", bus.reachable); end
    checks++; if (bus.distance !== 8'd0) begin errors++; $display("FAIL walled_dist got %0d want 0", bus.distance); end
  endtask

  task automatic test_serpentine();
    int cyc, pulses;
    set_snake(1'b0);
    // 15 rows of 9 horizontal steps plus 14 drops = 149 = W*H-1.
    run_solve(4'd0, 4'd0, 4'd9, 4'd14, cyc, pulses);
    checks++; if (cyc !== 151) begin errors++; $display("FAIL snake_cycle got %0d want 151", cyc); end
    checks++; if (bus.reachable !== 1'b1) begin errors++; $display("FAIL snake_reach got %b want 1", bus.reachable); end
    checks++; if (bus.distance !== 8'd149) begin errors++; $display("FAIL snake_dist got %0d want 149", bus.distance); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL snake_pulses got %0d want 1", pulses); end
    run_solve(4'd0, 4'd0, 4'd0, 4'd1, cyc, pulses);
    checks++; if (bus.distance !== 8'd19) begin errors++; $display("FAIL snake_row1_dist got %0d want 19", bus.distance); end
    checks++; if (cyc !== 21) begin errors++; $display("FAIL snake_row1_cycle got %0d want 21", cyc); end
    // Closing the row 2/3 gap leaves 30 cells reachable, farthest at 29 rings.
    set_snake(1'b1);
    run_solve(4'd0, 4'd0, 4'd0, 4'd14, cyc, pulses);
    checks++; if (bus.reachable !== 1'b0) begin errors++; $display("FAIL stall_reach got %b want 0", bus.reachable); end
    checks++; if (bus.distance !== 8'd29) begin errors++; $display("FAIL stall_dist got %0d want 29", bus.distance); end
    checks++; if (cyc !== 31) begin errors++; $display("FAIL stall_cycle got %0d want 31", cyc); end
  endtask

  task automatic test_hold();
    bus.h_walls = '0; bus.v_walls = '0;
    bus.dst_x = 4'd5;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy got %b want 0", bus.busy); end
    checks++; if (bus.distance !== 8'd29) begin errors++; $display("FAIL hold_dist got %0d want 29", bus.distance); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_done got %b want 0", bus.done); end
  endtask

  task automatic test_invalid_coord();
    int cyc, pulses;
    bus.h_walls = '0; bus.v_walls = '0;
    run_solve(4'd0, 4'd0, 4'd10, 4'd3, cyc, pulses);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL invalid_cycle got %0d want 1", cyc); end
    checks++; if (bus.reachable !== 1'b0) begin errors++; $display("FAIL invalid_reach got %b want 0", bus.reachable); end
    checks++; if (bus.distance !== 8'd0) begin errors++; $display("FAIL invalid_dist got %0d want 0", bus.distance); end
  endtask

  task automatic test_ignored_start();
    int cyc = -1;
    int pulses = 0;
    bus.h_walls = '0; bus.v_walls = '0;
    bus.src_x = 4'd0; bus.src_y = 4'd0; bus.dst_x = 4'd3; bus.dst_y = 4'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.done) begin
        pulses++;
        if (cyc < 0) cyc = n;
      end
      bus.start = 1'b0;
      if (n == 3) begin
        // A second request plus wall/coord changes mid-solve must be ignored.
        bus.start = 1'b1;
        bus.dst_x = 4'd0; bus.dst_y = 4'd0;
        bus.h_walls = '1; bus.v_walls = '1;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++; if (cyc !== 7) begin errors++; $display("FAIL b2b_cycle got %0d want 7", cyc); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    checks++; if (bus.distance !== 8'd5) begin errors++; $display("FAIL b2b_dist got %0d want 5", bus.distance); end
    checks++; if (bus.reachable !== 1'b1) begin errors++; $display("FAIL b2b_reach got %b want 1", bus.reachable); end
  endtask

  task automatic test_reset_mid();
    int cyc, pulses;
    bus.h_walls = '0; bus.v_walls = '0;
    bus.src_x = 4'd0; bus.src_y = 4'd0; bus.dst_x = 4'd9; bus.dst_y = 4'd14;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    checks++; if (bus.distance !== 8'd0) begin errors++; $display("FAIL rstmid_dist got %0d want 0", bus.distance); end
    checks++; if (bus.reachable !== 1'b0) begin errors++; $display("FAIL rstmid_reach got %b want 0", bus.reachable); end
    run_solve(4'd2, 4'd0, 4'd0, 4'd0, cyc, pulses);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL rstmid_after_cycle got %0d want 4", cyc); end
    checks++; if (bus.distance !== 8'd2) begin errors++; $display("FAIL rstmid_after_dist got %0d want 2", bus.distance); end
    checks++; if (bus.reachable !== 1'b1) begin errors++; $display("FAIL rstmid_after_reach got %b want 1", bus.reachable); end
  endtask

  initial begin
    test_reset();
    test_open_field();
    test_same_cell();
    test_all_walls();
    test_serpentine();
    test_hold();
    test_invalid_coord();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
